// File: rtl/rom_pkg.sv
// Shared types and defaults for the ROM burst reader front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rom_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ROM_DEPTH  = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_burst_reader.sv
// Walks a burst of consecutive ROM addresses (wrapping) and registers each word into a valid/ready stream.
// Latency: first beat valid two edges after start is sampled; one beat per cycle with out_ready high.
// Backpressure: out_ready low holds out_data/out_last/addr; abort cancels the burst and drops the pending beat.
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t            state_r, state_nxt;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  count_r;
  logic              launch;   // accept a non-empty burst in IDLE
  logic              load;     // capture rom_data into the output register
  logic              flush_hs; // final beat taken in FLUSH
  logic              kill;     // abort: drop pending beat

  assign rom_address = addr_r;
  assign busy        = (state_r != IDLE);

  // Next-state and per-cycle control; abort outranks start, load and handshake.
  always_comb begin
    state_nxt = state_r;
    launch    = 1'b0;
    load      = 1'b0;
    flush_hs  = 1'b0;
    kill      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          if (length != '0) begin
            launch    = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else if (!out_valid || out_ready) begin
          load = 1'b1;
          if (count_r == LEN_W'(1)) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (abort) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else if (out_valid && out_ready) begin
          flush_hs  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        kill      = abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt;
  end

  // Address walker and remaining-beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= '0;
      count_r <= '0;
    end else if (launch) begin
      addr_r  <= base_addr;
      count_r <= length;
    end else if (load) begin
      addr_r  <= addr_r + ADDR_W'(1);
      count_r <= count_r - LEN_W'(1);
    end
  end

  // Output register: replaced on load, cleared on final handshake or abort, else held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (kill || flush_hs) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= rom_data;
      out_valid <= 1'b1;
      out_last  <= (count_r == LEN_W'(1));
    end
  end

  // Completion pulse, issued the cycle after DONE unless that cycle is aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state_r == DONE) && !abort;
  end

endmodule
